// File: rtl/hc_sr04_pkg.sv
// Shared types and timing helpers for the HC-SR04 echo emulator.
// Tick conversions are evaluated at elaboration time.
package hc_sr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_BURST,
    ST_ECHO,
    ST_HOLDOFF
  } hc_sr04_emu_state_t;

  localparam int CNT_W = 22;
  localparam int SOUND_SPEED_M_S = 340;

  function automatic longint unsigned us_to_ticks(
    input longint unsigned clk_freq,
    input longint unsigned us
  );
    return (clk_freq * us) / 64'd1000000;
  endfunction

  // Round-trip time of flight for a target m metres away.
  function automatic longint unsigned m_to_echo_ticks(
    input longint unsigned clk_freq,
    input real m
  );
    real t;
    t = 2.0 * m / real'(SOUND_SPEED_M_S) * real'(clk_freq);
    return longint'(t);
  endfunction

endpackage

// File: rtl/hc_sr04_echo_emulator_sync.sv
// Multi-stage flop synchronizer for a single asynchronous bit.
// All stages reset to 0.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/hc_sr04_echo_emulator.sv
// HC-SR04 responder: validates trigger width, waits the burst delay,
// then drives an echo whose width is the programmed tick count.
module hc_sr04_echo_emulator
  import hc_sr04_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100000000,
  parameter int unsigned TRIG_MIN_US = 10,
  parameter int unsigned BURST_US    = 200,
  parameter int unsigned TIMEOUT_US  = 38000,
  parameter int unsigned HOLDOFF_US  = 100,
  parameter int          ECHO_WL     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sn_trigger,
  output logic               sn_edge,
  input  logic               cfg_valid,
  input  logic [ECHO_WL-1:0] cfg_ticks,
  input  logic               cfg_no_target,
  output logic               busy,
  output logic               trig_short,
  output logic               trig_ignored,
  output logic [15:0]        ping_count
);

  localparam longint unsigned TRIG_CNT =
    us_to_ticks(CLK_FREQ, TRIG_MIN_US);
  localparam longint unsigned BURST_CNT =
    us_to_ticks(CLK_FREQ, BURST_US);
  localparam longint unsigned TIMEOUT_CNT =
    us_to_ticks(CLK_FREQ, TIMEOUT_US);
  localparam longint unsigned HOLDOFF_CNT =
    us_to_ticks(CLK_FREQ, HOLDOFF_US);

  localparam logic [CNT_W-1:0] TRIG_C  = CNT_W'(TRIG_CNT);
  localparam logic [CNT_W-1:0] BURST_LD = CNT_W'(BURST_CNT - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLDOFF_CNT - 1);
  localparam logic [ECHO_WL-1:0] TIMEOUT_W = ECHO_WL'(TIMEOUT_CNT);

  hc_sr04_emu_state_t state;

  logic               trig_s;
  logic               trig_d;
  logic               rise_q;
  logic               fall_q;
  logic [ECHO_WL-1:0] ticks;
  logic               no_target;
  logic [ECHO_WL-1:0] len_sel;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   echo_len;
  logic               in_op;

  bit_synchronizer #(
    .STAGES(2)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sn_trigger),
    .q    (trig_s)
  );

  // Registered edge pulses: together with the synchronizer this is
  // the three-cycle latency from pin to FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_d <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      trig_d <= trig_s;
      rise_q <= trig_s & ~trig_d;
      fall_q <= ~trig_s & trig_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ticks     <= '0;
      no_target <= 1'b1;
    end else if (cfg_valid) begin
      ticks     <= cfg_ticks;
      no_target <= cfg_no_target;
    end
  end

  always_comb begin
    len_sel = ticks;
    if (no_target) begin
      len_sel = TIMEOUT_W;
    end else if (ticks == '0) begin
      len_sel = ECHO_WL'(1);
    end else if (ticks > TIMEOUT_W) begin
      len_sel = TIMEOUT_W;
    end
  end

  assign in_op = (state == ST_BURST) ||
                 (state == ST_ECHO) ||
                 (state == ST_HOLDOFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      echo_len     <= '0;
      sn_edge      <= 1'b0;
      busy         <= 1'b0;
      trig_short   <= 1'b0;
      trig_ignored <= 1'b0;
      ping_count   <= '0;
    end else begin
      trig_short   <= 1'b0;
      trig_ignored <= rise_q & in_op;
      unique case (state)
        ST_IDLE: begin
          if (rise_q) begin
            state <= ST_TRIG;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        ST_TRIG: begin
          if (fall_q) begin
            if (cnt >= TRIG_C) begin
              state      <= ST_BURST;
              cnt        <= BURST_LD;
              echo_len   <= CNT_W'(len_sel);
              ping_count <= ping_count + 16'd1;
            end else begin
              state      <= ST_IDLE;
              busy       <= 1'b0;
              trig_short <= 1'b1;
            end
          end else if (cnt < TRIG_C) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_BURST: begin
          if (cnt == '0) begin
            state   <= ST_ECHO;
            sn_edge <= 1'b1;
            cnt     <= echo_len - CNT_W'(1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_ECHO: begin
          if (cnt == '0) begin
            state   <= ST_HOLDOFF;
            sn_edge <= 1'b0;
            cnt     <= HOLD_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          sn_edge <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc_sr04_echo_emulator.sv
// Randomized bench for hc_sr04_echo_emulator at a scaled clock.
// Expected echo widths come from the length rules, not the RTL.
module tb_hc_sr04_echo_emulator;

  localparam int unsigned CF   = 1000000;
  localparam longint      TRIG = 10;
  localparam longint      B    = 200;
  localparam longint      TO   = 2000;
  localparam longint      HO   = 100;

  logic        clk;
  logic        reset;
  logic        sn_trigger;
  logic        sn_edge;
  logic        cfg_valid;
  logic [31:0] cfg_ticks;
  logic        cfg_no_target;
  logic        busy;
  logic        trig_short;
  logic        trig_ignored;
  logic [15:0] ping_count;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  int     n_short = 0;
  int     n_ign = 0;
  int     exp_pings = 0;
  longint t_fall = 0;

  hc_sr04_echo_emulator #(
    .CLK_FREQ   (CF),
    .TRIG_MIN_US(10),
    .BURST_US   (200),
    .TIMEOUT_US (2000),
    .HOLDOFF_US (100),
    .ECHO_WL    (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sn_trigger   (sn_trigger),
    .sn_edge      (sn_edge),
    .cfg_valid    (cfg_valid),
    .cfg_ticks    (cfg_ticks),
    .cfg_no_target(cfg_no_target),
    .busy         (busy),
    .trig_short   (trig_short),
    .trig_ignored (trig_ignored),
    .ping_count   (ping_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (trig_short) n_short++;
    if (trig_ignored) n_ign++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint model_len(input bit nt,
                                       input logic [31:0] t);
    if (nt) return TO;
    if (t == 0) return 1;
    if (longint'(t) > TO) return TO;
    return longint'(t);
  endfunction

  task automatic cfg(input logic [31:0] t, input bit nt);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_ticks = t;
    cfg_no_target = nt;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic trig_pulse(input int w);
    @(negedge clk);
    sn_trigger = 1'b1;
    repeat (w) @(negedge clk);
    sn_trigger = 1'b0;
    t_fall = cyc + 1;
  endtask

  task automatic wait_rise(input int budget, output longint r);
    int n;
    n = 0;
    r = -1;
    while (!sn_edge && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sn_edge) r = cyc;
  endtask

  task automatic wait_fall(input longint r, output longint width,
                           output longint f);
    int n;
    width = -1;
    f = -1;
    if (r < 0) return;
    n = 0;
    while (sn_edge && n < TO + 50) begin
      @(negedge clk);
      n++;
    end
    if (sn_edge) return;
    f = cyc;
    width = f - r;
  endtask

  task automatic wait_idle(input longint f, output longint gap);
    int n;
    gap = -1;
    if (f < 0) return;
    n = 0;
    while (busy && n < HO + 50) begin
      @(negedge clk);
      n++;
    end
    if (!busy) gap = cyc - f;
  endtask

  task automatic ping(input int w, output longint dly,
                      output longint width, output longint gap);
    longint r;
    longint f;
    trig_pulse(w);
    wait_rise(int'(B) + 50, r);
    dly = (r < 0) ? -1 : r - t_fall;
    wait_fall(r, width, f);
    wait_idle(f, gap);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    sn_trigger = 1'b0;
    cfg_valid = 1'b0;
    cfg_ticks = '0;
    cfg_no_target = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sn_edge !== 1'b0) begin
      errors++;
      $display("FAIL reset_sn_edge: got %0b want 0", sn_edge);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %0b want 0", busy);
    end
    checks++;
    if (trig_short !== 1'b0 || trig_ignored !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got %0b%0b want 00",
               trig_short, trig_ignored);
    end
    checks++;
    if (ping_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_ping_count: got %0d want 0", ping_count);
    end
    reset = 1'b0;
    exp_pings = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_default_no_target;
    longint d, w, g;
    ping(15, d, w, g);
    exp_pings++;
    checks++;
    if (w !== TO) begin
      errors++;
      $display("FAIL default_width: got %0d want %0d", w, TO);
    end
  endtask

  task automatic test_accepted;
    longint d, w, g;
    logic [31:0] t;
    for (int i = 0; i < 3; i++) begin
      t = 32'($urandom_range(1, 1500));
      cfg(t, 1'b0);
      ping(int'($urandom_range(12, 30)), d, w, g);
      exp_pings++;
      checks++;
      if (d !== B + 3) begin
        errors++;
        $display("FAIL accept_delay: got %0d want %0d", d, B + 3);
      end
      checks++;
      if (w !== model_len(1'b0, t)) begin
        errors++;
        $display("FAIL accept_width: got %0d want %0d",
                 w, model_len(1'b0, t));
      end
      checks++;
      if (g !== HO) begin
        errors++;
        $display("FAIL accept_holdoff: got %0d want %0d", g, HO);
      end
      checks++;
      if (ping_count !== 16'(exp_pings)) begin
        errors++;
        $display("FAIL accept_count: got %0d want %0d",
                 ping_count, exp_pings);
      end
    end
  endtask

  task automatic test_short;
    longint r;
    int s0;
    for (int i = 0; i < 3; i++) begin
      s0 = n_short;
      trig_pulse(int'($urandom_range(2, 8)));
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL short_idle: busy got %0b want 0", busy);
      end
      wait_rise(int'(B) + 50, r);
      checks++;
      if (r !== -1) begin
        errors++;
        $display("FAIL short_no_echo: echo at %0d want none", r);
      end
      checks++;
      if (n_short - s0 !== 1) begin
        errors++;
        $display("FAIL short_pulse: got %0d want 1", n_short - s0);
      end
      checks++;
      if (ping_count !== 16'(exp_pings)) begin
        errors++;
        $display("FAIL short_count: got %0d want %0d",
                 ping_count, exp_pings);
      end
    end
  endtask

  task automatic test_clamp;
    logic [31:0] tv [6];
    bit          nv [6];
    longint d, w, g;
    tv[0] = 32'($urandom_range(1, 500)); nv[0] = 1'b1;
    tv[1] = 32'd5000;                    nv[1] = 1'b0;
    tv[2] = 32'd0;                       nv[2] = 1'b0;
    tv[3] = 32'(TO);                     nv[3] = 1'b0;
    tv[4] = 32'(TO + 1);                 nv[4] = 1'b0;
    tv[5] = 32'hFFFF_FFFF;               nv[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cfg(tv[i], nv[i]);
      ping(20, d, w, g);
      exp_pings++;
      checks++;
      if (w !== model_len(nv[i], tv[i])) begin
        errors++;
        $display("FAIL clamp_%0d: got %0d want %0d",
                 i, w, model_len(nv[i], tv[i]));
      end
    end
  endtask

  task automatic test_retrigger;
    longint r, w, f, g, r2;
    int i0;
    cfg(32'd800, 1'b0);
    trig_pulse(15);
    wait_rise(int'(B) + 50, r);
    exp_pings++;
    i0 = n_ign;
    trig_pulse(15);
    wait_fall(r, w, f);
    wait_idle(f, g);
    checks++;
    if (w !== 800) begin
      errors++;
      $display("FAIL retrig_width: got %0d want 800", w);
    end
    checks++;
    if (n_ign - i0 !== 1) begin
      errors++;
      $display("FAIL retrig_ignored: got %0d want 1", n_ign - i0);
    end
    wait_rise(int'(B) + 100, r2);
    checks++;
    if (r2 !== -1) begin
      errors++;
      $display("FAIL retrig_no_second: echo at %0d want none", r2);
    end
    checks++;
    if (ping_count !== 16'(exp_pings)) begin
      errors++;
      $display("FAIL retrig_count: got %0d want %0d",
               ping_count, exp_pings);
    end
  endtask

  task automatic test_level_high;
    longint r, w, f, r2;
    int i0;
    cfg(32'd50, 1'b0);
    trig_pulse(15);
    wait_rise(int'(B) + 50, r);
    wait_fall(r, w, f);
    exp_pings++;
    repeat (20) @(negedge clk);
    i0 = n_ign;
    sn_trigger = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL level_busy: got %0b want 0", busy);
    end
    sn_trigger = 1'b0;
    wait_rise(int'(B) + 50, r2);
    checks++;
    if (r2 !== -1 || n_ign - i0 !== 1) begin
      errors++;
      $display("FAIL level_reject: echo %0d ign %0d want -1 1",
               r2, n_ign - i0);
    end
    checks++;
    if (ping_count !== 16'(exp_pings)) begin
      errors++;
      $display("FAIL level_count: got %0d want %0d",
               ping_count, exp_pings);
    end
  endtask

  task automatic test_cfg_mid;
    longint r, w, f, g, d;
    cfg(32'd300, 1'b0);
    trig_pulse(15);
    repeat (50) @(negedge clk);
    cfg(32'd600, 1'b0);
    wait_rise(int'(B) + 50, r);
    wait_fall(r, w, f);
    wait_idle(f, g);
    exp_pings++;
    checks++;
    if (w !== 300) begin
      errors++;
      $display("FAIL cfgmid_first: got %0d want 300", w);
    end
    ping(15, d, w, g);
    exp_pings++;
    checks++;
    if (w !== 600) begin
      errors++;
      $display("FAIL cfgmid_next: got %0d want 600", w);
    end
  endtask

  task automatic test_reset_mid;
    longint r, d, w, g;
    cfg(32'd1000, 1'b0);
    trig_pulse(15);
    wait_rise(int'(B) + 50, r);
    repeat (500) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (sn_edge !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_edge: got %0b want 0", sn_edge);
    end
    checks++;
    if (ping_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_count: got %0d want 0", ping_count);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_pings = 0;
    cfg(32'd400, 1'b0);
    ping(15, d, w, g);
    exp_pings++;
    checks++;
    if (d !== B + 3 || w !== 400) begin
      errors++;
      $display("FAIL rstmid_next: delay %0d width %0d want %0d 400",
               d, w, B + 3);
    end
    checks++;
    if (ping_count !== 16'(exp_pings)) begin
      errors++;
      $display("FAIL rstmid_next_count: got %0d want %0d",
               ping_count, exp_pings);
    end
  endtask

  task automatic test_back_to_back;
    longint d, w, g;
    logic [31:0] t;
    bit nt;
    for (int i = 0; i < 5; i++) begin
      nt = ($urandom_range(0, 3) == 0);
      t = 32'($urandom_range(0, int'(TO) + 500));
      cfg(t, nt);
      ping(int'($urandom_range(12, 40)), d, w, g);
      exp_pings++;
      checks++;
      if (w !== model_len(nt, t) || d !== B + 3) begin
        errors++;
        $display("FAIL b2b_%0d: width %0d delay %0d want %0d %0d",
                 i, w, d, model_len(nt, t), B + 3);
      end
      checks++;
      if (ping_count !== 16'(exp_pings)) begin
        errors++;
        $display("FAIL b2b_count: got %0d want %0d",
                 ping_count, exp_pings);
      end
    end
  endtask

  initial begin
    test_reset;
    test_default_no_target;
    test_accepted;
    test_short;
    test_clamp;
    test_retrigger;
    test_level_high;
    test_cfg_mid;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
